// File: rtl/lut_breadboard_pkg.sv
// Shared types and sizing helpers for the LUT breadboard.
package lut_breadboard_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default geometry: 4-input functions, 10 of them.
  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_NUM_OUT = 10;

  // Bits in one truth table: one bit per input combination.
  function automatic int table_width(input int num_in);
    return 1 << num_in;
  endfunction

  // Width of the table-select field; never narrower than one bit.
  function automatic int sel_width(input int num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/lut_cell.sv
// One programmable logic function: a truth-table register with a registered
// evaluation read and a combinational read for the sweep stream.
module lut_cell
  import lut_breadboard_pkg::*;
#(
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int TBL_W  = table_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [TBL_W-1:0]  wr_table,
  input  logic [NUM_IN-1:0] eval_in,
  input  logic [NUM_IN-1:0] sweep_index,
  output logic              eval_bit,
  output logic              sweep_bit
);

  // Bit i holds the function value for input combination i (first input = MSB).
  logic [TBL_W-1:0] table_q;

  // Truth-table storage, loaded whole on a write strobe.
  // NOTE: the table is a plain register rather than a RAM, so clearing it on
  // reset is legal and required; a memory macro could not be reset this way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      table_q <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge
      // values, so a write and a read in the same cycle never race.
      table_q <= wr_table;
    end
  end

  // Direct evaluation: one cycle of latency from eval_in to eval_bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eval_bit <= 1'b0;
    end else begin
      eval_bit <= table_q[eval_in];
    end
  end

  // Sweep read is combinational; the controller owns its timing.
  assign sweep_bit = table_q[sweep_index];

endmodule

// File: rtl/lut_breadboard.sv
// Bank of programmable truth tables with a direct-evaluation port and a
// handshaked sweep engine that streams every input combination in order.
module lut_breadboard
  import lut_breadboard_pkg::*;
#(
  parameter  int NUM_IN  = DEF_NUM_IN,
  parameter  int NUM_OUT = DEF_NUM_OUT,
  localparam int TBL_W   = table_width(NUM_IN),
  localparam int SEL_W   = sel_width(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  // Truth-table write port
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [TBL_W-1:0]   cfg_table,
  // Direct evaluation
  input  logic [NUM_IN-1:0]  eval_in,
  output logic [NUM_OUT-1:0] eval_out,
  // Sweep control
  input  logic               sweep_start,
  output logic               busy,
  // Sweep result stream
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_IN-1:0]  out_index,
  output logic [NUM_OUT-1:0] out_result,
  output logic               sweep_done
);

  // Last input combination of a sweep; a handshake here ends the sweep.
  localparam logic [NUM_IN-1:0] IDX_LAST = '1;

  state_t             state;
  state_t             next_state;
  logic [NUM_IN-1:0]  index;
  logic [NUM_IN-1:0]  next_index;
  logic               cfg_fire;
  logic [NUM_OUT-1:0] sweep_bits;

  // Writes are taken only while idle; out-of-range selects match no cell
  // and are therefore accepted and dropped.
  assign cfg_fire = cfg_valid && cfg_ready;

  // One cell per output function.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_cell
    lut_cell #(
      .NUM_IN (NUM_IN)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (cfg_fire && (int'(cfg_sel) == k)),
      .wr_table    (cfg_table),
      .eval_in     (eval_in),
      .sweep_index (index),
      .eval_bit    (eval_out[k]),
      .sweep_bit   (sweep_bits[k])
    );
  end

  // Controller state and sweep index; reset aborts any sweep in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= next_state;
      index <= next_index;
    end
  end

  // Next-state logic and control outputs for the sweep controller.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    next_state = state;
    next_index = index;
    cfg_ready  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    sweep_done = 1'b0;

    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (sweep_start) begin
          next_state = RUN;
          next_index = '0;
        end
      end

      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          if (index == IDX_LAST) begin
            // Stop on the last beat; the index is not wrapped.
            next_state = DONE;
          end else begin
            next_index = index + 1'b1;
          end
        end
      end

      DONE: begin
        busy       = 1'b1;
        sweep_done = 1'b1;
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Stream payload is driven only during a beat and is otherwise zero. Tables
  // cannot change in RUN (writes need IDLE), and the index only moves on a
  // handshake, so a stalled beat holds steady by construction.
  assign out_index  = out_valid ? index : '0;
  assign out_result = out_valid ? sweep_bits : '0;

endmodule
